// File: rtl/downlink_pcm_receiver.sv
// downlink_pcm_receiver
// Ground-side PCM consumer of the A22 downlink logic. Generates the DKSTRT
// word-start pulse and the DKBSNC bit-sync strobes, samples the returned
// serial stream (DKDATA or DKDATB) and assembles 40-bit downlink words.
// Completed words go to the telemetry-frame logic through a 2-entry
// valid/ready buffer with a sticky overrun flag.
//
// Optional feature: define DOWNLINK_PARITY_EN to add the PARERR port. Each
// buffered word then carries an odd-parity check of its CH34 and CH35 halves.
// With the macro undefined the port and all parity logic are absent.

module downlink_pcm_receiver #(
    parameter int FRAME_BITS = 40,
    parameter int BIT_DIV    = 8,
    parameter int SAMPLE_DLY = 2,
    parameter int WORD_GAP   = 16
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  ENABLE,
    input  logic                  DATSEL,
    input  logic                  DKDATA,
    input  logic                  DKDATB,
    output logic                  DKSTRT,
    output logic                  DKBSNC,
    output logic                  DKEND,
    output logic                  WORD_VALID,
    input  logic                  WORD_READY,
    output logic [FRAME_BITS-1:0] WORD_DATA,
    output logic                  OVERRUN,
    input  logic                  CLR_OVR
`ifdef DOWNLINK_PARITY_EN
    ,
    output logic [1:0]            PARERR
`endif
);

    // One counter serves both the bit period and the inter-word gap.
    localparam int CNT_MAX = (BIT_DIV > WORD_GAP) ? BIT_DIV : WORD_GAP;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int BW      = $clog2(FRAME_BITS);

    // Half-word boundaries for the CH34 / CH35 parity checks.
    localparam int HI_MSB = FRAME_BITS - 2;
    localparam int HI_LSB = FRAME_BITS - 17;
    localparam int LO_MSB = FRAME_BITS - 18;
    localparam int LO_LSB = FRAME_BITS - 33;

    // Buffer entries carry the parity flags alongside the word when enabled.
`ifdef DOWNLINK_PARITY_EN
    localparam int EW = FRAME_BITS + 2;
`else
    localparam int EW = FRAME_BITS;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_END,
        S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cyc_q, cyc_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic                  datsel_q, datsel_d;

    logic [1:0]            cnt_q, cnt_d;
    logic [EW-1:0]         head_q, head_d;
    logic [EW-1:0]         tail_q, tail_d;
    logic                  ovr_q, ovr_d;

    logic                  din;
    logic                  push;
    logic                  pop;
    logic [EW-1:0]         push_entry;

    // Serial input chosen by the channel select latched for this word.
    assign din = datsel_q ? DKDATB : DKDATA;

    // Word sequencer state, counters, shifter and latched channel select.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            sr_q     <= '0;
            datsel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            sr_q     <= sr_d;
            datsel_q <= datsel_d;
        end
    end

    // Next-state logic: start pulse, 40 bit periods, end pulse, idle gap.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        sr_d     = sr_q;
        datsel_d = datsel_q;
        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                bit_d = '0;
                if (ENABLE) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                bit_d = '0;
                if (cyc_q == '0) begin
                    datsel_d = DATSEL;
                end
                if (cyc_q == CW'(BIT_DIV - 1)) begin
                    cyc_d   = '0;
                    state_d = S_BIT;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_BIT: begin
                if (cyc_q == CW'(SAMPLE_DLY)) begin
                    sr_d = {sr_q[FRAME_BITS-2:0], din};
                end
                if (cyc_q == CW'(BIT_DIV - 1)) begin
                    cyc_d = '0;
                    if (bit_q == BW'(FRAME_BITS - 1)) begin
                        state_d = S_END;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_END: begin
                cyc_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cyc_q == CW'(WORD_GAP - 1)) begin
                    cyc_d   = '0;
                    state_d = ENABLE ? S_START : S_IDLE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                cyc_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes to the A22 are decoded from registered state so reset kills them at once.
    always_comb begin
        DKSTRT = (state_q == S_START);
        DKBSNC = (state_q == S_BIT) && (cyc_q < CW'(BIT_DIV / 2));
        DKEND  = (state_q == S_END);
    end

    // The assembled word enters the buffer on the edge that closes the DKEND cycle.
    assign push = (state_q == S_END);

`ifdef DOWNLINK_PARITY_EN
    assign push_entry = {~^sr_q[HI_MSB:HI_LSB], ~^sr_q[LO_MSB:LO_LSB], sr_q};
`else
    assign push_entry = sr_q;
`endif

    assign WORD_VALID = (cnt_q != 2'd0);
    assign pop        = WORD_VALID && WORD_READY;
    assign WORD_DATA  = head_q[FRAME_BITS-1:0];
    assign OVERRUN    = ovr_q;

`ifdef DOWNLINK_PARITY_EN
    assign PARERR = head_q[EW-1:FRAME_BITS];
`endif

    // Buffer storage: registered head entry, second slot, occupancy and overrun flag.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            ovr_q  <= ovr_d;
        end
    end

    // Buffer update: simultaneous push/pop keeps occupancy, push into a full buffer drops the word.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        ovr_d  = ovr_q;
        if (CLR_OVR) begin
            ovr_d = 1'b0;
        end
        case ({push, pop})
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = push_entry;
                end else begin
                    head_d = tail_q;
                    tail_d = push_entry;
                end
            end
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = push_entry;
                    cnt_d  = 2'd1;
                end else if (cnt_q == 2'd1) begin
                    tail_d = push_entry;
                    cnt_d  = 2'd2;
                end else begin
                    ovr_d = 1'b1;
                end
            end
            2'b01: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = '0;
                    cnt_d  = 2'd1;
                end else begin
                    head_d = '0;
                    cnt_d  = 2'd0;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

endmodule

// File: tb/tb_downlink_pcm_receiver.sv
// tb_downlink_pcm_receiver
// Directed bench for downlink_pcm_receiver. A reactive driver plays a
// 40-bit word onto DKDATA/DKDATB MSB-first, one bit per DKBSNC strobe.
// Expected words are queued as stimulus is issued; a monitor pops and
// compares them whenever the DUT hands a word over.

module tb_downlink_pcm_receiver;

    localparam int FRAME_BITS = 40;
    localparam int BIT_DIV    = 8;
    localparam int SAMPLE_DLY = 2;
    localparam int WORD_GAP   = 16;

    logic                  clk;
    logic                  rst_;
    logic                  ENABLE;
    logic                  DATSEL;
    logic                  DKDATA;
    logic                  DKDATB;
    logic                  DKSTRT;
    logic                  DKBSNC;
    logic                  DKEND;
    logic                  WORD_VALID;
    logic                  WORD_READY;
    logic [FRAME_BITS-1:0] WORD_DATA;
    logic                  OVERRUN;
    logic                  CLR_OVR;
`ifdef DOWNLINK_PARITY_EN
    logic [1:0]            PARERR;
`endif

    int checks = 0;
    int errors = 0;

    logic [FRAME_BITS-1:0] expQ[$];
    logic [FRAME_BITS-1:0] expWord;
    logic [FRAME_BITS-1:0] txWordA = '0;
    logic [FRAME_BITS-1:0] txWordB = '0;

    int   txIdx          = 0;
    logic bsncPrev       = 1'b0;
    logic validPrev      = 1'b0;
    int   cycleCount     = 0;
    int   strtCycles     = 0;
    int   bsncCycles     = 0;
    int   bsncRises      = 0;
    int   endCycles      = 0;
    int   validCycles    = 0;
    int   validRises     = 0;
    int   lastEndCycle   = 0;
    int   validRiseCycle = 0;

    downlink_pcm_receiver #(
        .FRAME_BITS(FRAME_BITS),
        .BIT_DIV   (BIT_DIV),
        .SAMPLE_DLY(SAMPLE_DLY),
        .WORD_GAP  (WORD_GAP)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .ENABLE    (ENABLE),
        .DATSEL    (DATSEL),
        .DKDATA    (DKDATA),
        .DKDATB    (DKDATB),
        .DKSTRT    (DKSTRT),
        .DKBSNC    (DKBSNC),
        .DKEND     (DKEND),
        .WORD_VALID(WORD_VALID),
        .WORD_READY(WORD_READY),
        .WORD_DATA (WORD_DATA),
        .OVERRUN   (OVERRUN),
        .CLR_OVR   (CLR_OVR)
`ifdef DOWNLINK_PARITY_EN
        ,
        .PARERR    (PARERR)
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a wait ever slips past its own bound.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=still_running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=timeout required=event", name);
    endtask

    // Serial data driver plus event counters, all sampled on the falling edge.
    initial begin
        DKDATA = 1'b0;
        DKDATB = 1'b0;
        forever begin
            @(negedge clk);
            cycleCount++;
            if (DKSTRT) begin
                strtCycles++;
                txIdx = 0;
            end
            if (DKBSNC) bsncCycles++;
            if (DKBSNC && !bsncPrev) begin
                bsncRises++;
                if (txIdx < FRAME_BITS) begin
                    DKDATA = txWordA[FRAME_BITS-1-txIdx];
                    DKDATB = txWordB[FRAME_BITS-1-txIdx];
                end
                txIdx++;
            end
            if (DKEND) begin
                endCycles++;
                lastEndCycle = cycleCount;
            end
            if (WORD_VALID) validCycles++;
            if (WORD_VALID && !validPrev) begin
                validRises++;
                validRiseCycle = cycleCount;
            end
            bsncPrev  = DKBSNC;
            validPrev = WORD_VALID;
        end
    end

    // Scoreboard monitor: every handshake must match the oldest queued word.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_ && WORD_VALID && WORD_READY) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_unexpected_word actual=%0h required=none", WORD_DATA);
                end else begin
                    expWord = expQ.pop_front();
                    checkOutput("sb_word", WORD_DATA, expWord);
`ifdef DOWNLINK_PARITY_EN
                    checkOutput("sb_parerr", PARERR,
                                {~^expWord[38:23], ~^expWord[22:7]});
`endif
                end
            end
        end
    end

    task automatic waitForStart(input int budget);
        int waited = 0;
        while (!DKSTRT && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (!DKSTRT) reportTimeout("wait_dkstrt");
    endtask

    task automatic waitForBit(input int base, input int n, input int budget);
        int waited = 0;
        while ((bsncRises - base) < n && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if ((bsncRises - base) < n) reportTimeout("wait_bit");
    endtask

    task automatic waitForEnd(input int budget);
        int waited = 0;
        while (!DKEND && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (!DKEND) reportTimeout("wait_dkend");
    endtask

    // Runs one word: optional DATSEL flip at bit togAt, ENABLE dropped at bit dropAt.
    task automatic applyStimulus(input logic [FRAME_BITS-1:0] aWord,
                                 input logic [FRAME_BITS-1:0] bWord,
                                 input logic sel, input int togAt, input int dropAt);
        int base;
        @(posedge clk);
        #1;
        txWordA = aWord;
        txWordB = bWord;
        DATSEL  = sel;
        ENABLE  = 1'b1;
        waitForStart(50);
        base = bsncRises;
        if (togAt >= 0) begin
            waitForBit(base, togAt, FRAME_BITS * BIT_DIV + 50);
            #1 DATSEL = ~sel;
        end
        waitForBit(base, dropAt, FRAME_BITS * BIT_DIV + 50);
        #1 ENABLE = 1'b0;
        waitForEnd(FRAME_BITS * BIT_DIV + 50);
        repeat (WORD_GAP + 4) @(negedge clk);
    endtask

    int s0, s1, s2, s3, s4, s5, baseBit;

    initial begin
        rst_       = 1'b0;
        ENABLE     = 1'b0;
        DATSEL     = 1'b0;
        WORD_READY = 1'b1;
        CLR_OVR    = 1'b0;

        // Reset and idle
        #23;
        checkOutput("rst_dkstrt", DKSTRT, 0);
        checkOutput("rst_dkbsnc", DKBSNC, 0);
        rst_ = 1'b1;
        s0 = strtCycles;
        repeat (100) @(negedge clk);
        checkOutput("idle_dkstrt", DKSTRT, 0);
        checkOutput("idle_dkbsnc", DKBSNC, 0);
        checkOutput("idle_dkend", DKEND, 0);
        checkOutput("idle_valid", WORD_VALID, 0);
        checkOutput("idle_data", WORD_DATA, 0);
        checkOutput("idle_overrun", OVERRUN, 0);
        checkOutput("idle_no_start", strtCycles - s0, 0);
`ifdef DOWNLINK_PARITY_EN
        checkOutput("idle_parerr", PARERR, 0);
`endif

        // Single word on channel A with full strobe timing checks
        s0 = strtCycles; s1 = bsncRises; s2 = bsncCycles;
        s3 = endCycles;  s4 = validCycles;
        expQ.push_back(40'h8AAAA55550);
        applyStimulus(40'h8AAAA55550, 40'h0, 1'b0, -1, 2);
        checkOutput("word1_dkstrt_cycles", strtCycles - s0, BIT_DIV);
        checkOutput("word1_bsnc_pulses", bsncRises - s1, FRAME_BITS);
        checkOutput("word1_bsnc_high", bsncCycles - s2, FRAME_BITS * (BIT_DIV / 2));
        checkOutput("word1_dkend_cycles", endCycles - s3, 1);
        checkOutput("word1_latency", validRiseCycle - lastEndCycle, 1);
        checkOutput("word1_valid_cycles", validCycles - s4, 1);

        // Channel B select, then a DATSEL flip mid-word that must not matter
        expQ.push_back(40'hFFFFFFFFFF);
        applyStimulus(40'h0, 40'hFFFFFFFFFF, 1'b1, -1, 3);
        expQ.push_back(40'h123456789A);
        applyStimulus(40'hFEDCBA9876, 40'h123456789A, 1'b1, 20, 25);

        // Back-pressure: two words held, third dropped with overrun
        @(posedge clk);
        #1 WORD_READY = 1'b0;
        expQ.push_back(40'hA5A5A5A5A5);
        applyStimulus(40'hA5A5A5A5A5, 40'h0, 1'b0, -1, 4);
        expQ.push_back(40'h5A5A5A5A5A);
        applyStimulus(40'h5A5A5A5A5A, 40'h0, 1'b0, -1, 4);
        checkOutput("bp_no_overrun_yet", OVERRUN, 0);
        applyStimulus(40'hC3C3C3C3C3, 40'h0, 1'b0, -1, 4);
        checkOutput("bp_overrun_set", OVERRUN, 1);
        checkOutput("bp_valid_held", WORD_VALID, 1);
        checkOutput("bp_head_is_first", WORD_DATA, 40'hA5A5A5A5A5);
        @(posedge clk);
        #1 WORD_READY = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("bp_drained_valid", WORD_VALID, 0);
        checkOutput("bp_drained_queue", expQ.size(), 0);
        checkOutput("bp_overrun_sticky", OVERRUN, 1);
        @(posedge clk);
        #1 CLR_OVR = 1'b1;
        @(posedge clk);
        #1 CLR_OVR = 1'b0;
        checkOutput("bp_overrun_cleared", OVERRUN, 0);

        // ENABLE dropped at bit 20: word completes, then no further starts
        s0 = strtCycles;
        expQ.push_back(40'h3C3C3C3C3C);
        applyStimulus(40'h3C3C3C3C3C, 40'h0, 1'b0, -1, 20);
        repeat (100) @(negedge clk);
        checkOutput("endrop_single_start", strtCycles - s0, BIT_DIV);

        // Reset at bit 10: strobes drop immediately, partial word never appears
        @(posedge clk);
        #1;
        txWordA = 40'hFFFF0000FF;
        DATSEL  = 1'b0;
        ENABLE  = 1'b1;
        waitForStart(50);
        baseBit = bsncRises;
        waitForBit(baseBit, 10, FRAME_BITS * BIT_DIV + 50);
        checkOutput("rstmid_bsnc_before", DKBSNC, 1);
        #2 rst_ = 1'b0;
        #1;
        checkOutput("rstmid_dkstrt", DKSTRT, 0);
        checkOutput("rstmid_dkbsnc", DKBSNC, 0);
        checkOutput("rstmid_valid", WORD_VALID, 0);
        ENABLE = 1'b0;
        #20 rst_ = 1'b1;
        s0 = strtCycles; s5 = validRises;
        repeat (100) @(negedge clk);
        checkOutput("rstmid_no_start", strtCycles - s0, 0);
        checkOutput("rstmid_no_word", validRises - s5, 0);

        // Fresh start after reset delivers normally
        expQ.push_back(40'h0F0F0F0F0F);
        applyStimulus(40'h0F0F0F0F0F, 40'h0, 1'b0, -1, 5);

`ifdef DOWNLINK_PARITY_EN
        // CH34 = 0001 (odd, good), CH35 = 0003 (even, bad)
        @(posedge clk);
        #1 WORD_READY = 1'b0;
        expQ.push_back(40'h0000800180);
        applyStimulus(40'h0000800180, 40'h0, 1'b0, -1, 5);
        checkOutput("parity_flags", PARERR, 2'b01);
        @(posedge clk);
        #1 WORD_READY = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("parity_empty", PARERR, 0);
`endif

        repeat (10) @(negedge clk);
        checkOutput("sb_all_delivered", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
